counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 112 +++++++++++
 tb/tb_counter_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/pause/clear controlled up-counter with a one-cycle terminal pulse.
// Optional build macro: COUNTER_CTRL_AUTO_RELOAD_EN
//   undefined (default): terminal count moves to DONE and holds cnt at the target.
//   defined:             terminal count wraps cnt to 0, pulses done and stays in RUN.
module counter_ctrl #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_target;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_target_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_start_ok;
  logic             w_at_target;

  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_at_target = (r_cnt == r_target);

  // State, count, latched target and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and datapath: clear > start > pause > terminal check > increment.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_done_nxt   = 1'b0;

    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_start_ok) begin
      w_state_nxt  = ST_RUN;
      w_cnt_nxt    = '0;
      w_target_nxt = target;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_at_target) begin
            w_done_nxt = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
            w_cnt_nxt  = '0;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            // cnt < target_q here, so the CNT_W-bit add never wraps.
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PAUSE: begin
          // Resume without counting on this edge.
          if (!pause) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          // IDLE and DONE hold until start or clear.
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
  end

  assign cnt   = r_cnt;
  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed, table-driven bench for counter_ctrl. Each vector is one rising edge:
// inputs are driven before the edge and outputs are compared 1ns after it.
// Build with COUNTER_CTRL_AUTO_RELOAD_EN to check the auto-reload variant.
module tb_counter_ctrl;

  localparam int unsigned CNT_W = 7;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             pause;
  logic             clear;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  typedef struct {
    logic             rst_n;
    logic             start;
    logic             pause;
    logic             clear;
    logic [CNT_W-1:0] target;
    logic [1:0]       exp_state;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  counter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .pause  (pause),
    .clear  (clear),
    .target (target),
    .cnt    (cnt),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int r, input int s, input int p, input int c, input int tgt,
                     input logic [1:0] st, input int ec, input int eb, input int ed);
    vec_t v;
    v.rst_n     = 1'(r);
    v.start     = 1'(s);
    v.pause     = 1'(p);
    v.clear     = 1'(c);
    v.target    = CNT_W'(tgt);
    v.exp_state = st;
    v.exp_cnt   = CNT_W'(ec);
    v.exp_busy  = 1'(eb);
    v.exp_done  = 1'(ed);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst_n  = v.rst_n;
    start  = v.start;
    pause  = v.pause;
    clear  = v.clear;
    target = v.target;
    @(posedge clk);
    #1;
    n_checks++;
    if ({state, cnt, busy, done} !== {v.exp_state, v.exp_cnt, v.exp_busy, v.exp_done}) begin
      n_fail++;
      $display("FAIL %s: got state=%0d cnt=%0d busy=%0b done=%0b, expected state=%0d cnt=%0d busy=%0b done=%0b",
               tag, state, cnt, busy, done, v.exp_state, v.exp_cnt, v.exp_busy, v.exp_done);
    end
  endtask

  task automatic fill_table();
    // Reset with every input active: inputs must be ignored.
    add(0, 1, 1, 1, 9, S_IDLE, 0, 0, 0);
    add(0, 1, 0, 0, 9, S_IDLE, 0, 0, 0);
    // Start in the first cycle after reset, target=5.
    add(1, 1, 0, 0, 5, S_RUN, 0, 1, 0);
    for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, 0, S_RUN, k, 1, 0);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    add(1, 0, 0, 0, 0, S_RUN, 0, 1, 1);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 2, 1, 0);
    // Target 2 after a restart via clear + start: 0,1,2,0,1,2,0 with done on each wrap.
    add(1, 0, 0, 1, 0, S_IDLE, 0, 0, 0);
    add(1, 1, 0, 0, 2, S_RUN, 0, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 2, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 0, 1, 1);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 2, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 0, 1, 1);
    add(1, 1, 0, 0, 0, S_RUN, 1, 1, 0);  // start ignored in RUN
    add(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0); // reset mid-run
    add(1, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
`else
    add(1, 0, 0, 0, 0, S_DONE, 5, 0, 1);
    add(1, 0, 0, 0, 0, S_DONE, 5, 0, 0);
    add(1, 0, 1, 0, 0, S_DONE, 5, 0, 0);  // pause ignored in DONE
    // target=0 from DONE; mid-run start with target=3 must be ignored.
    add(1, 1, 0, 0, 0, S_RUN, 0, 1, 0);
    add(1, 1, 0, 0, 3, S_DONE, 0, 0, 1);
    add(1, 0, 0, 0, 3, S_DONE, 0, 0, 0);
    // start and clear together resolve as clear.
    add(1, 1, 0, 1, 4, S_IDLE, 0, 0, 0);
    // Terminal check suppressed while pause is high; start ignored in PAUSE.
    add(1, 1, 0, 0, 2, S_RUN, 0, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 2, 1, 0);
    add(1, 0, 1, 0, 0, S_PAUSE, 2, 1, 0);
    add(1, 1, 1, 0, 0, S_PAUSE, 2, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 2, 1, 0);
    add(1, 0, 0, 0, 0, S_DONE, 2, 0, 1);
    // Reset mid-run discards the sequence with no done pulse.
    add(1, 1, 0, 0, 5, S_RUN, 0, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
    add(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
    add(1, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
`endif
    // Clear at cnt=6 in RUN; pause in IDLE is ignored.
    add(1, 1, 0, 0, 8, S_RUN, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, 0, 0, 0, S_RUN, k, 1, 0);
    add(1, 0, 0, 1, 0, S_IDLE, 0, 0, 0);
    add(1, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
    add(1, 0, 1, 0, 0, S_IDLE, 0, 0, 0);
    // target=10, pause high for 3 edges at cnt=4.
    add(1, 1, 0, 0, 10, S_RUN, 0, 1, 0);
    for (int k = 1; k <= 4; k++) add(1, 0, 0, 0, 0, S_RUN, k, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 0, S_PAUSE, 4, 1, 0);
    add(1, 0, 0, 0, 0, S_RUN, 4, 1, 0);
    for (int k = 5; k <= 10; k++) add(1, 0, 0, 0, 0, S_RUN, k, 1, 0);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    add(1, 0, 0, 0, 0, S_RUN, 0, 1, 1);
    add(1, 0, 0, 0, 0, S_RUN, 1, 1, 0);
`else
    add(1, 0, 0, 0, 0, S_DONE, 10, 0, 1);
    add(1, 0, 0, 0, 0, S_DONE, 10, 0, 0);
`endif
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    target   = '0;

    fill_table();
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // All-ones target: counts to 127 without wrapping.
    v = '{rst_n: 1'b0, start: 1'b0, pause: 1'b0, clear: 1'b0, target: '0,
          exp_state: S_IDLE, exp_cnt: '0, exp_busy: 1'b0, exp_done: 1'b0};
    apply(v, "max_reset");
    v.rst_n = 1'b1; v.start = 1'b1; v.target = CNT_W'(127);
    v.exp_state = S_RUN; v.exp_busy = 1'b1;
    apply(v, "max_start");
    v.start = 1'b0; v.target = '0;
    for (int k = 1; k <= 127; k++) begin
      v.exp_cnt = CNT_W'(k);
      apply(v, $sformatf("max_cnt%0d", k));
    end
    v.exp_done = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    v.exp_cnt = '0;
`else
    v.exp_state = S_DONE; v.exp_busy = 1'b0;
`endif
    apply(v, "max_terminal");
    v.exp_done = 1'b0;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    v.exp_cnt = CNT_W'(1);
`endif
    apply(v, "max_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
